// File: rtl/noc_pkg.sv
// Shared NoC definitions for the PageRank router slice.
//   NOC_PORTS : default number of queues competing for one output link
//   FLIT_W    : default flit payload width
//   state_t   : port-arbiter control states
//   next_idx  : modulo-n increment used to advance round-robin pointers
package noc_pkg;

    localparam int unsigned NOC_PORTS = 4;
    localparam int unsigned FLIT_W    = 16;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    // Wraps n-1 back to 0; valid for non-power-of-two n.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   valid : request vector
//   ptr   : highest-priority index; scan order is ptr, ptr+1, ... mod N
//   sel   : one-hot select of the first valid index in scan order
//   idx   : binary index of that selection
//   any   : at least one request is valid
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   sel,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int unsigned j;

    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!any && valid[j]) begin
                any    = 1'b1;
                sel[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin output-link arbiter with bounded burst lock.
//   clk, reset   : clock and asynchronous active-high reset
//   valid_in     : per-queue non-empty flags (first-word-fall-through heads)
//   data_in      : head words, queue i at [i*WIDTH +: WIDTH]
//   full,
//   almost_full  : downstream FIFO backpressure
//   read_out     : one-hot combinational pop strobe to the granted queue
//   data_out,
//   write_out    : registered flit and write strobe to the downstream FIFO
//   grant_id     : index of the last granted queue
//   busy         : high while a burst owner holds the link
module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH     = FLIT_W,
    parameter int unsigned N_IN      = NOC_PORTS,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IDW       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN-1:0]       valid_in,
    input  logic [N_IN*WIDTH-1:0] data_in,
    input  logic                  full,
    input  logic                  almost_full,
    output logic [N_IN-1:0]       read_out,
    output logic [WIDTH-1:0]      data_out,
    output logic                  write_out,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  owner;
    logic [CW-1:0]   cnt;

    logic [N_IN-1:0] pick_sel;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    logic            can_send;
    logic            grant;
    logic [IDW-1:0]  gnt_idx;
    logic            release_burst;
    logic [N_IN-1:0] owner_sel;

    // almost_full rather than full alone: one flit may still sit in the output register.
    assign can_send = !full && !almost_full;

    rr_pick #(
        .N   (N_IN),
        .IDW (IDW)
    ) u_pick (
        .valid (valid_in),
        .ptr   (ptr),
        .sel   (pick_sel),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Release spends one cycle with no grant, which gives the next owner a clean start.
    assign release_burst = (state == ST_BURST) &&
                           (!valid_in[owner] || cnt == CW'(MAX_BURST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_idx   = owner;
        case (state)
            ST_IDLE: begin
                if (can_send && pick_any) begin
                    grant   = 1'b1;
                    gnt_idx = pick_idx;
                    if (MAX_BURST > 1) state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (release_burst) state_nxt = ST_IDLE;
                else if (can_send) grant = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_sel = N_IN'(1) << owner;
        read_out  = '0;
        // Gated by reset so no pop escapes while the arbiter is held in reset.
        if (grant && !reset) read_out = (state == ST_IDLE) ? pick_sel : owner_sel;
        busy = (state == ST_BURST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            write_out <= 1'b0;
            grant_id  <= '0;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
        end else begin
            write_out <= grant;
            if (grant) begin
                data_out <= data_in[gnt_idx*WIDTH +: WIDTH];
                grant_id <= gnt_idx;
            end
            if (grant && state == ST_IDLE) begin
                owner <= gnt_idx;
                cnt   <= CW'(1);
                if (MAX_BURST == 1) ptr <= IDW'(next_idx(32'(gnt_idx), N_IN));
            end else if (grant) begin
                cnt <= cnt + CW'(1);
            end
            if (release_burst) ptr <= IDW'(next_idx(32'(owner), N_IN));
        end
    end

endmodule
